// File: rtl/xsim_dma_burst_if.sv
// Request/response bundle for xsim_dma_burst together with the
// simDma word-access layer (host memory) that the engine calls into.
interface xsim_dma_burst_if #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
);
  logic                  en_init;
  logic [31:0]           init_id;
  logic [31:0]           init_handle;
  logic [31:0]           init_size;
  logic                  en_initfd;
  logic [31:0]           initfd_id;
  logic [31:0]           initfd_fd;
  logic                  rdy_readrequest;
  logic                  en_readrequest;
  logic [31:0]           readrequest_handle;
  logic [31:0]           readrequest_addr;
  logic [LEN_WIDTH-1:0]  readrequest_len;
  logic                  rdy_readresponse;
  logic                  en_readresponse;
  logic [DATA_WIDTH-1:0] readresponse_data;
  logic                  readresponse_last;
  logic                  rdy_writerequest;
  logic                  en_writerequest;
  logic [31:0]           writerequest_handle;
  logic [31:0]           writerequest_addr;
  logic [LEN_WIDTH-1:0]  writerequest_len;
  logic                  rdy_writedata;
  logic                  en_writedata;
  logic [DATA_WIDTH-1:0] writedata_data;
  logic                  writedone;

  // host memory, one 32-bit word per {handle, byte address}
  bit [31:0]   host_mem [bit [63:0]];
  bit [95:0]   last_init;
  bit [63:0]   last_initfd;
  int unsigned dma_calls;

  function automatic void simDma_init(
    input logic [31:0] id,
    input logic [31:0] handle,
    input logic [31:0] size
  );
    last_init = {id, handle, size};
    dma_calls = dma_calls + 1;
  endfunction

  function automatic void simDma_initfd(
    input logic [31:0] id,
    input logic [31:0] fd
  );
    last_initfd = {id, fd};
    dma_calls = dma_calls + 1;
  endfunction

  function automatic logic [31:0] read_simDma32(
    input logic [31:0] handle,
    input logic [31:0] addr
  );
    dma_calls = dma_calls + 1;
    return host_mem[{handle, addr}];
  endfunction

  function automatic void write_simDma32(
    input logic [31:0] handle,
    input logic [31:0] addr,
    input logic [31:0] data
  );
    host_mem[{handle, addr}] = data;
    dma_calls = dma_calls + 1;
  endfunction

  modport master (
    output en_init, init_id, init_handle, init_size,
    output en_initfd, initfd_id, initfd_fd,
    input  rdy_readrequest,
    output en_readrequest, readrequest_handle,
    output readrequest_addr, readrequest_len,
    input  rdy_readresponse, readresponse_data,
    input  readresponse_last,
    output en_readresponse,
    input  rdy_writerequest,
    output en_writerequest, writerequest_handle,
    output writerequest_addr, writerequest_len,
    input  rdy_writedata,
    output en_writedata, writedata_data,
    input  writedone
  );

  modport slave (
    input  en_init, init_id, init_handle, init_size,
    input  en_initfd, initfd_id, initfd_fd,
    output rdy_readrequest,
    input  en_readrequest, readrequest_handle,
    input  readrequest_addr, readrequest_len,
    output rdy_readresponse, readresponse_data,
    output readresponse_last,
    input  en_readresponse,
    output rdy_writerequest,
    input  en_writerequest, writerequest_handle,
    input  writerequest_addr, writerequest_len,
    output rdy_writedata,
    input  en_writedata, writedata_data,
    output writedone,
    import simDma_init, simDma_initfd,
    import read_simDma32, write_simDma32
  );
endinterface

// File: rtl/xsim_dma_burst.sv
// Multi-beat simulation DMA endpoint: independent read and write burst
// engines over simDma word calls, read beats buffered in a response FIFO.
module xsim_dma_burst #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input logic             CLK,
  input logic             RST_N,
  xsim_dma_burst_if.slave bus
);
  localparam int WPB = DATA_WIDTH / 32;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BPB  = 32'(DATA_WIDTH / 8);
  localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_BURST = 1'b1;
  localparam logic [0:0] WR_IDLE  = 1'b0;
  localparam logic [0:0] WR_DATA  = 1'b1;

  logic [0:0]           rd_state;
  logic [31:0]          rd_handle;
  logic [31:0]          rd_addr;
  logic [LEN_WIDTH-1:0] rd_len;
  logic [LEN_WIDTH-1:0] rd_cnt;

  logic [0:0]           wr_state;
  logic [31:0]          wr_handle;
  logic [31:0]          wr_addr;
  logic [LEN_WIDTH-1:0] wr_len;
  logic [LEN_WIDTH-1:0] wr_cnt;
  logic                 writedone_q;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  logic                 rd_accept;
  logic                 rd_active;
  logic                 rd_final;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [31:0]          rd_h;
  logic [31:0]          rd_a;
  logic [LEN_WIDTH-1:0] rd_l;
  logic [LEN_WIDTH-1:0] rd_c;

  // the accepting cycle already issues beat 0 so it is visible next cycle
  always_comb begin
    rd_accept = (rd_state == RD_IDLE) && bus.en_readrequest;
    rd_active = rd_accept || (rd_state == RD_BURST);
    rd_h      = rd_accept ? bus.readrequest_handle : rd_handle;
    rd_a      = rd_accept ? bus.readrequest_addr : rd_addr;
    rd_l      = rd_accept ? bus.readrequest_len : rd_len;
    rd_c      = rd_accept ? '0 : rd_cnt;
    rd_final  = (rd_c == rd_l);
    fifo_pop  = bus.en_readresponse && (count != '0);
    fifo_push = rd_active && ((count < FULL) || fifo_pop);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_state    <= RD_IDLE;
      rd_handle   <= '0;
      rd_addr     <= '0;
      rd_len      <= '0;
      rd_cnt      <= '0;
      wr_state    <= WR_IDLE;
      wr_handle   <= '0;
      wr_addr     <= '0;
      wr_len      <= '0;
      wr_cnt      <= '0;
      writedone_q <= 1'b0;
      fifo_last   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
    end else begin
      // call order within a cycle: init, initfd, read, write
      if (bus.en_init) begin
        bus.simDma_init(bus.init_id, bus.init_handle,
                        bus.init_size);
      end
      if (bus.en_initfd) begin
        bus.simDma_initfd(bus.initfd_id, bus.initfd_fd);
      end

      if (fifo_push) begin
        for (int j = 0; j < WPB; j++) begin
          fifo_data[wr_ptr][32*j +: 32] <=
            bus.read_simDma32(rd_h, rd_a + 32'(4 * j));
        end
        fifo_last[wr_ptr] <= rd_final;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (fifo_push != fifo_pop) begin
        count <= fifo_push ? count + 1'b1 : count - 1'b1;
      end

      if (rd_active) begin
        rd_handle <= rd_h;
        rd_len    <= rd_l;
        rd_addr   <= fifo_push ? rd_a + BPB : rd_a;
        rd_cnt    <= fifo_push ? rd_c + 1'b1 : rd_c;
        rd_state  <= (fifo_push && rd_final) ? RD_IDLE : RD_BURST;
      end

      writedone_q <= 1'b0;
      unique case (wr_state)
        WR_IDLE: begin
          if (bus.en_writerequest) begin
            wr_handle <= bus.writerequest_handle;
            wr_addr   <= bus.writerequest_addr;
            wr_len    <= bus.writerequest_len;
            wr_cnt    <= '0;
            wr_state  <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (bus.en_writedata) begin
            for (int j = 0; j < WPB; j++) begin
              bus.write_simDma32(wr_handle,
                                 wr_addr + 32'(4 * j),
                                 bus.writedata_data[32*j +: 32]);
            end
            wr_addr <= wr_addr + BPB;
            wr_cnt  <= wr_cnt + 1'b1;
            if (wr_cnt == wr_len) begin
              wr_state    <= WR_IDLE;
              writedone_q <= 1'b1;
            end
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  assign bus.rdy_readrequest   = (rd_state == RD_IDLE);
  assign bus.rdy_readresponse  = (count != '0);
  assign bus.readresponse_data = fifo_data[rd_ptr];
  assign bus.readresponse_last = fifo_last[rd_ptr];
  assign bus.rdy_writerequest  = (wr_state == WR_IDLE);
  assign bus.rdy_writedata     = (wr_state == WR_DATA);
  assign bus.writedone         = writedone_q;
endmodule

// File: tb/tb_xsim_dma_burst.sv
// Self-checking bench for xsim_dma_burst: randomized bursts checked
// against a word-addressed memory model and an expected-beat queue.
module tb_xsim_dma_burst;
  localparam int DW  = 64;
  localparam int FD  = 4;
  localparam int LW  = 8;
  localparam int WPB = DW / 32;
  localparam int BPB = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  xsim_dma_burst_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  xsim_dma_burst #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .LEN_WIDTH(LW)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  bit [31:0] ref_mem [bit [63:0]];
  beat_t exp_q [$];

  function automatic void preload(input logic [31:0] h,
                                  input logic [31:0] a,
                                  input logic [31:0] d);
    ref_mem[{h, a}] = d;
    bus.host_mem[{h, a}] = d;
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [31:0] h,
                                               input logic [31:0] base,
                                               input int k);
    logic [DW-1:0] b;
    logic [31:0]   a;
    a = base + 32'(k * BPB);
    for (int j = 0; j < WPB; j++) b[32*j +: 32] = ref_mem[{h, a + 32'(4*j)}];
    return b;
  endfunction

  function automatic void preload_rand(input logic [31:0] h,
                                       input logic [31:0] base,
                                       input int beats);
    for (int i = 0; i < beats * WPB; i++) preload(h, base + 32'(4*i), $urandom);
  endfunction

  function automatic void expect_burst(input logic [31:0] h,
                                       input logic [31:0] base,
                                       input int len);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.data = model_beat(h, base, k);
      b.last = (k == len);
      exp_q.push_back(b);
    end
  endfunction

  task automatic drive_idle();
    bus.en_init = 0; bus.en_initfd = 0;
    bus.en_readrequest = 0; bus.en_readresponse = 0;
    bus.en_writerequest = 0; bus.en_writedata = 0;
  endtask

  task automatic read_req(input logic [31:0] h, input logic [31:0] a,
                          input int len);
    @(negedge CLK);
    bus.readrequest_handle = h;
    bus.readrequest_addr   = a;
    bus.readrequest_len    = LW'(len);
    bus.en_readrequest     = 1;
    @(negedge CLK);
    bus.en_readrequest = 0;
  endtask

  task automatic test_reset();
    int unsigned c0;
    #1 RST_N = 0;
    #2;
    n_checks++;
    if (bus.rdy_readrequest !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy_readrequest: got %b expected 1", bus.rdy_readrequest);
    end
    n_checks++;
    if (bus.rdy_readresponse !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy_readresponse: got %b expected 0", bus.rdy_readresponse);
    end
    n_checks++;
    if (bus.rdy_writerequest !== 1'b1 || bus.rdy_writedata !== 1'b0) begin
      n_fail++; $display("FAIL reset_write_rdy: got %b/%b expected 1/0", bus.rdy_writerequest, bus.rdy_writedata);
    end
    n_checks++;
    if (bus.writedone !== 1'b0) begin
      n_fail++; $display("FAIL reset_writedone: got %b expected 0", bus.writedone);
    end
    n_checks++;
    if (bus.readresponse_data !== '0 || bus.readresponse_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_head: got %h/%b expected 0/0", bus.readresponse_data, bus.readresponse_last);
    end
    c0 = bus.dma_calls;
    bus.en_init = 1;
    bus.en_readrequest = 1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (bus.dma_calls !== c0) begin
      n_fail++; $display("FAIL reset_no_calls: got %0d calls expected %0d", bus.dma_calls, c0);
    end
    drive_idle();
    RST_N = 1;
    @(negedge CLK);
  endtask

  task automatic test_init();
    logic [31:0] id, hd, sz, fid, fd;
    int unsigned c0;
    id = $urandom; hd = $urandom; sz = $urandom; fid = $urandom; fd = $urandom;
    c0 = bus.dma_calls;
    bus.init_id = id; bus.init_handle = hd; bus.init_size = sz;
    bus.initfd_id = fid; bus.initfd_fd = fd;
    bus.en_init = 1; bus.en_initfd = 1;
    @(negedge CLK);
    drive_idle();
    n_checks++;
    if (bus.last_init !== {id, hd, sz}) begin
      n_fail++; $display("FAIL init_args: got %h expected %h", bus.last_init, {id, hd, sz});
    end
    n_checks++;
    if (bus.last_initfd !== {fid, fd}) begin
      n_fail++; $display("FAIL initfd_args: got %h expected %h", bus.last_initfd, {fid, fd});
    end
    n_checks++;
    if (bus.dma_calls - c0 !== 2) begin
      n_fail++; $display("FAIL init_calls: got %0d expected 2", bus.dma_calls - c0);
    end
  endtask

  task automatic test_single_read();
    logic [31:0] h;
    h = 32'h5;
    preload(h, 32'h100, 32'h11111111);
    preload(h, 32'h104, 32'h22222222);
    read_req(h, 32'h100, 0);
    n_checks++;
    if (bus.rdy_readresponse !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: rdy_readresponse %b expected 1", bus.rdy_readresponse);
    end
    n_checks++;
    if (bus.readresponse_data !== 64'h22222222_11111111 || bus.readresponse_last !== 1'b1) begin
      n_fail++; $display("FAIL single_beat: got %h/%b expected 2222222211111111/1", bus.readresponse_data, bus.readresponse_last);
    end
    n_checks++;
    if (bus.rdy_readrequest !== 1'b1) begin
      n_fail++; $display("FAIL single_idle: rdy_readrequest %b expected 1", bus.rdy_readrequest);
    end
    bus.en_readresponse = 1;
    @(negedge CLK);
    bus.en_readresponse = 0;
    n_checks++;
    if (bus.rdy_readresponse !== 1'b0) begin
      n_fail++; $display("FAIL single_empty: rdy_readresponse %b expected 0", bus.rdy_readresponse);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h, a;
    int unsigned c0, c1;
    logic [DW-1:0] e;
    h = $urandom; a = $urandom & 32'hFFFF_FFFC;
    preload_rand(h, a, 10);
    c0 = bus.dma_calls;
    read_req(h, a, 9);
    repeat (9) @(negedge CLK);
    n_checks++;
    if (bus.dma_calls - c0 !== 4 * WPB) begin
      n_fail++; $display("FAIL bp_buffered_calls: got %0d expected %0d", bus.dma_calls - c0, 4 * WPB);
    end
    n_checks++;
    if (bus.rdy_readresponse !== 1'b1 || bus.rdy_readrequest !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall_rdy: got %b/%b expected 1/0", bus.rdy_readresponse, bus.rdy_readrequest);
    end
    // one pop while full: the engine refills the freed slot in the same cycle
    e = model_beat(h, a, 0);
    n_checks++;
    if (bus.readresponse_data !== e || bus.readresponse_last !== 1'b0) begin
      n_fail++; $display("FAIL bp_beat0: got %h/%b expected %h/0", bus.readresponse_data, bus.readresponse_last, e);
    end
    c1 = bus.dma_calls;
    bus.en_readresponse = 1;
    @(negedge CLK);
    bus.en_readresponse = 0;
    n_checks++;
    if (bus.dma_calls - c1 !== WPB) begin
      n_fail++; $display("FAIL bp_full_pushpop: got %0d calls expected %0d", bus.dma_calls - c1, WPB);
    end
    c1 = bus.dma_calls;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (bus.dma_calls !== c1) begin
      n_fail++; $display("FAIL bp_still_full: got %0d extra calls expected 0", bus.dma_calls - c1);
    end
    for (int k = 1; k <= 9; k++) begin
      e = model_beat(h, a, k);
      n_checks++;
      if (bus.readresponse_data !== e || bus.readresponse_last !== (k == 9)) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", k, bus.readresponse_data, bus.readresponse_last, e, k == 9);
      end
      bus.en_readresponse = 1;
      @(negedge CLK);
    end
    bus.en_readresponse = 0;
    n_checks++;
    if (bus.rdy_readresponse !== 1'b0 || bus.rdy_readrequest !== 1'b1) begin
      n_fail++; $display("FAIL bp_done: got rsp %b req %b expected 0/1", bus.rdy_readresponse, bus.rdy_readrequest);
    end
  endtask

  task automatic test_write_wrap();
    logic [31:0] h, base, ad;
    logic [DW-1:0] d;
    int unsigned c0;
    h = $urandom; base = 32'hFFFF_FFF0;
    c0 = bus.dma_calls;
    bus.writedata_data = {2{$urandom}};
    bus.en_writedata = 1;
    @(negedge CLK);
    bus.en_writedata = 0;
    n_checks++;
    if (bus.dma_calls !== c0) begin
      n_fail++; $display("FAIL wr_idle_data: got %0d calls expected 0", bus.dma_calls - c0);
    end
    bus.writerequest_handle = h;
    bus.writerequest_addr   = base;
    bus.writerequest_len    = LW'(3);
    bus.en_writerequest     = 1;
    @(negedge CLK);
    bus.en_writerequest = 0;
    n_checks++;
    if (bus.rdy_writedata !== 1'b1 || bus.rdy_writerequest !== 1'b0) begin
      n_fail++; $display("FAIL wr_accept: got %b/%b expected 1/0", bus.rdy_writedata, bus.rdy_writerequest);
    end
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        n_checks++;
        if (bus.writedone !== 1'b0) begin
          n_fail++; $display("FAIL wr_gap_done: got 1 expected 0");
        end
      end
      d = {(DW/8){8'hA0 + 8'(k)}};
      ad = base + 32'(k * BPB);
      for (int j = 0; j < WPB; j++) ref_mem[{h, ad + 32'(4*j)}] = d[32*j +: 32];
      bus.writedata_data = d;
      bus.en_writedata = 1;
      @(negedge CLK);
      bus.en_writedata = 0;
      n_checks++;
      if (bus.writedone !== (k == 3)) begin
        n_fail++; $display("FAIL wr_done_beat%0d: got %b expected %b", k, bus.writedone, k == 3);
      end
    end
    @(negedge CLK);
    n_checks++;
    if (bus.writedone !== 1'b0 || bus.rdy_writerequest !== 1'b1) begin
      n_fail++; $display("FAIL wr_done_once: got done %b idle %b expected 0/1", bus.writedone, bus.rdy_writerequest);
    end
    n_checks++;
    if (bus.host_mem[{h, 32'h0}] !== 32'hA2A2A2A2 || bus.host_mem[{h, 32'h8}] !== 32'hA3A3A3A3) begin
      n_fail++; $display("FAIL wr_wrap_addr: got %h %h expected a2a2a2a2 a3a3a3a3", bus.host_mem[{h, 32'h0}], bus.host_mem[{h, 32'h8}]);
    end
    for (int i = 0; i < 4 * WPB; i++) begin
      ad = base + 32'(4*i);
      n_checks++;
      if (bus.host_mem[{h, ad}] !== ref_mem[{h, ad}]) begin
        n_fail++; $display("FAIL wr_word@%h: got %h expected %h", ad, bus.host_mem[{h, ad}], ref_mem[{h, ad}]);
      end
    end
    // readback through the read engine
    expect_burst(h, base, 3);
    read_req(h, base, 3);
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      bus.en_readresponse = 0;
      if (bus.rdy_readresponse && $urandom_range(0, 3) != 0) begin
        n_checks++;
        if (bus.readresponse_data !== exp_q[0].data || bus.readresponse_last !== exp_q[0].last) begin
          n_fail++; $display("FAIL wr_readback: got %h/%b expected %h/%b", bus.readresponse_data, bus.readresponse_last, exp_q[0].data, exp_q[0].last);
        end
        void'(exp_q.pop_front());
        bus.en_readresponse = 1;
      end
      @(negedge CLK);
    end
    bus.en_readresponse = 0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL wr_readback_timeout: %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] hr, ar, hw, aw, ad;
    logic [DW-1:0] d;
    int wk, pulses;
    hr = $urandom; ar = $urandom & 32'hFFFF_FFFC;
    hw = hr + 1; aw = $urandom & 32'hFFFF_FFFC;
    preload_rand(hr, ar, 4);
    expect_burst(hr, ar, 3);
    @(negedge CLK);
    bus.readrequest_handle = hr; bus.readrequest_addr = ar;
    bus.readrequest_len = LW'(3); bus.en_readrequest = 1;
    bus.writerequest_handle = hw; bus.writerequest_addr = aw;
    bus.writerequest_len = LW'(3); bus.en_writerequest = 1;
    @(negedge CLK);
    bus.en_readrequest = 0; bus.en_writerequest = 0;
    wk = 0; pulses = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.en_writedata = 0; bus.en_readresponse = 0;
      if (bus.writedone === 1'b1) pulses++;
      if (wk < 4 && bus.rdy_writedata) begin
        d = {$urandom, $urandom};
        ad = aw + 32'(wk * BPB);
        for (int j = 0; j < WPB; j++) ref_mem[{hw, ad + 32'(4*j)}] = d[32*j +: 32];
        bus.writedata_data = d; bus.en_writedata = 1; wk++;
      end
      if (bus.rdy_readresponse && exp_q.size() != 0) begin
        n_checks++;
        if (bus.readresponse_data !== exp_q[0].data || bus.readresponse_last !== exp_q[0].last) begin
          n_fail++; $display("FAIL conc_read: got %h/%b expected %h/%b", bus.readresponse_data, bus.readresponse_last, exp_q[0].data, exp_q[0].last);
        end
        void'(exp_q.pop_front());
        bus.en_readresponse = 1;
      end
      @(negedge CLK);
    end
    drive_idle();
    n_checks++;
    if (exp_q.size() != 0 || wk != 4) begin
      n_fail++; $display("FAIL conc_complete: %0d read beats left, %0d write beats sent, expected 0/4", exp_q.size(), wk);
      exp_q.delete();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL conc_writedone: got %0d pulses expected 1", pulses);
    end
    for (int i = 0; i < 4 * WPB; i++) begin
      ad = aw + 32'(4*i);
      n_checks++;
      if (bus.host_mem[{hw, ad}] !== ref_mem[{hw, ad}]) begin
        n_fail++; $display("FAIL conc_word@%h: got %h expected %h", ad, bus.host_mem[{hw, ad}], ref_mem[{hw, ad}]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] h, a;
    int unsigned c0;
    int len;
    h = $urandom; a = $urandom & 32'hFFFF_FFFC;
    preload_rand(h, a, 8);
    c0 = bus.dma_calls;
    read_req(h, a, 7);
    @(posedge CLK);
    #2;
    n_checks++;
    if (bus.dma_calls - c0 !== 2 * WPB) begin
      n_fail++; $display("FAIL rst_two_buffered: got %0d calls expected %0d", bus.dma_calls - c0, 2 * WPB);
    end
    RST_N = 0;
    c0 = bus.dma_calls;
    #1;
    n_checks++;
    if (bus.rdy_readresponse !== 1'b0 || bus.readresponse_data !== '0) begin
      n_fail++; $display("FAIL rst_async: got rdy %b data %h expected 0/0", bus.rdy_readresponse, bus.readresponse_data);
    end
    bus.en_init = 1; bus.en_readrequest = 1; bus.en_writerequest = 1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (bus.dma_calls !== c0) begin
      n_fail++; $display("FAIL rst_no_calls: got %0d calls expected 0", bus.dma_calls - c0);
    end
    drive_idle();
    RST_N = 1;
    @(negedge CLK);
    n_checks++;
    if (bus.rdy_readrequest !== 1'b1 || bus.rdy_readresponse !== 1'b0) begin
      n_fail++; $display("FAIL rst_release: got req %b rsp %b expected 1/0", bus.rdy_readrequest, bus.rdy_readresponse);
    end
    len = $urandom_range(0, 6);
    a = $urandom & 32'hFFFF_FFFC;
    preload_rand(h, a, len + 1);
    expect_burst(h, a, len);
    read_req(h, a, len);
    for (int cyc = 0; cyc < 60 && exp_q.size() != 0; cyc++) begin
      bus.en_readresponse = 0;
      if (bus.rdy_readresponse && $urandom_range(0, 2) != 0) begin
        n_checks++;
        if (bus.readresponse_data !== exp_q[0].data || bus.readresponse_last !== exp_q[0].last) begin
          n_fail++; $display("FAIL rst_new_burst: got %h/%b expected %h/%b", bus.readresponse_data, bus.readresponse_last, exp_q[0].data, exp_q[0].last);
        end
        void'(exp_q.pop_front());
        bus.en_readresponse = 1;
      end
      @(negedge CLK);
    end
    bus.en_readresponse = 0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rst_new_timeout: %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_random_bursts();
    logic [31:0] h, a, ad;
    logic [DW-1:0] d;
    int len, k, pulses;
    for (int it = 0; it < 5; it++) begin
      h = $urandom; a = $urandom & 32'hFFFF_FFFC;
      len = $urandom_range(0, 12);
      preload_rand(h, a, len + 1);
      expect_burst(h, a, len);
      read_req(h, a, len);
      for (int cyc = 0; cyc < 120 && exp_q.size() != 0; cyc++) begin
        bus.en_readresponse = 0;
        if (bus.rdy_readresponse && $urandom_range(0, 2) != 0) begin
          n_checks++;
          if (bus.readresponse_data !== exp_q[0].data || bus.readresponse_last !== exp_q[0].last) begin
            n_fail++; $display("FAIL rand_read%0d: got %h/%b expected %h/%b", it, bus.readresponse_data, bus.readresponse_last, exp_q[0].data, exp_q[0].last);
          end
          void'(exp_q.pop_front());
          bus.en_readresponse = 1;
        end
        @(negedge CLK);
      end
      bus.en_readresponse = 0;
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++; $display("FAIL rand_read%0d_timeout: %0d beats left expected 0", it, exp_q.size());
        exp_q.delete();
      end

      a = $urandom & 32'hFFFF_FFFC;
      len = $urandom_range(0, 5);
      bus.writerequest_handle = h; bus.writerequest_addr = a;
      bus.writerequest_len = LW'(len); bus.en_writerequest = 1;
      @(negedge CLK);
      bus.en_writerequest = 0;
      k = 0; pulses = 0;
      for (int cyc = 0; cyc < 50 && k <= len; cyc++) begin
        bus.en_writedata = 0;
        if (bus.writedone === 1'b1) pulses++;
        if ($urandom_range(0, 2) != 0) begin
          d = {$urandom, $urandom};
          ad = a + 32'(k * BPB);
          for (int j = 0; j < WPB; j++) ref_mem[{h, ad + 32'(4*j)}] = d[32*j +: 32];
          bus.writedata_data = d; bus.en_writedata = 1; k++;
        end
        @(negedge CLK);
      end
      bus.en_writedata = 0;
      repeat (2) begin
        if (bus.writedone === 1'b1) pulses++;
        @(negedge CLK);
      end
      n_checks++;
      if (pulses != 1) begin
        n_fail++; $display("FAIL rand_write%0d_done: got %0d pulses expected 1", it, pulses);
      end
      for (int i = 0; i < (len + 1) * WPB; i++) begin
        ad = a + 32'(4*i);
        n_checks++;
        if (bus.host_mem[{h, ad}] !== ref_mem[{h, ad}]) begin
          n_fail++; $display("FAIL rand_write%0d@%h: got %h expected %h", it, ad, bus.host_mem[{h, ad}], ref_mem[{h, ad}]);
        end
      end
    end
  endtask

  initial begin
    drive_idle();
    bus.init_id = '0; bus.init_handle = '0; bus.init_size = '0;
    bus.initfd_id = '0; bus.initfd_fd = '0;
    bus.readrequest_handle = '0; bus.readrequest_addr = '0;
    bus.readrequest_len = '0;
    bus.writerequest_handle = '0; bus.writerequest_addr = '0;
    bus.writerequest_len = '0; bus.writedata_data = '0;
    test_reset();
    test_init();
    test_single_read();
    test_backpressure();
    test_write_wrap();
    test_concurrent();
    test_reset_mid_burst();
    test_random_bursts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
